// File: rtl/hera_dmem_responder.sv
// Data-memory responder: word read/write with programmable wait states,
// per-word {sign,zero} flag tags and a busy stall toward the core.
module hera_dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              ram_flag_wr,
  input  logic              ram_flag_rd,
  input  logic [1:0]        flags_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [2:0]        flags_from_ram,
  output logic              err
);

  localparam int         DEPTH   = 2**ADDR_W;
  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr_q;
  logic                r_flag_rd_q;
  logic                r_pend_rd;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [1:0]          r_tag [DEPTH];
  logic [DEPTH-1:0]    r_tag_vld;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic [2:0]          r_flags;
  logic                r_err;

  logic                w_accept;
  logic                w_wr;
  logic                w_rd;
  logic                w_resp_now;
  logic [ADDR_W-1:0]   w_resp_addr;
  logic                w_resp_flag;
  logic                w_resp_vld;

  // Read+write together is served as a write only.
  assign w_accept    = (r_state != S_WAIT) && (ram_read || ram_write);
  assign w_wr        = w_accept && ram_write;
  assign w_rd        = w_accept && ram_read && !ram_write;
  assign w_resp_now  = (w_rd && (WAIT_CYCLES == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0) && r_pend_rd);
  assign w_resp_addr = (r_state == S_WAIT) ? r_addr_q : ram_addr;
  assign w_resp_flag = (r_state == S_WAIT) ? r_flag_rd_q : ram_flag_rd;
  assign w_resp_vld  = r_tag_vld[w_resp_addr];

  // Storage arrays carry no reset; only the tag-valid bits are cleared.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[ram_addr] <= ram_data;
      r_tag[ram_addr] <= ram_flag_wr ? flags_in : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr_q    <= '0;
      r_flag_rd_q <= 1'b0;
      r_pend_rd   <= 1'b0;
      r_tag_vld   <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_flags     <= 3'b000;
      r_err       <= 1'b0;
    end else begin
      r_rd_valid <= w_resp_now;
      r_err      <= w_accept && ram_read && ram_write;
      r_flags    <= 3'b000;
      if (w_resp_now) begin
        r_rd_data <= r_mem[w_resp_addr];
        if (w_resp_flag)
          r_flags <= {w_resp_vld, r_tag[w_resp_addr] & {2{w_resp_vld}}};
      end
      if (w_wr)
        r_tag_vld[ram_addr] <= ram_flag_wr;

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_addr_q    <= ram_addr;
            r_flag_rd_q <= ram_flag_rd && w_rd;
            r_pend_rd   <= w_rd;
            if (WAIT_CYCLES == 0) begin
              r_state <= w_rd ? S_RESP : S_IDLE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_M1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= r_pend_rd ? S_RESP : S_IDLE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state == S_WAIT);
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign flags_from_ram = r_flags;
  assign err            = r_err;

endmodule

// File: tb/tb_hera_dmem_responder.sv
// Bench for hera_dmem_responder: three instances (0, 1 and 3 wait states)
// checked against an array-based memory/tag model.
module tb_hera_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [15:0] wdat [3];
  logic        fwr  [3];
  logic        frd  [3];
  logic [1:0]  fin  [3];
  logic [15:0] rdd  [3];
  logic        rv   [3];
  logic        bsy  [3];
  logic [2:0]  ffr  [3];
  logic        er   [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_mem   [3][4096];
  bit          m_known [3][4096];
  logic [1:0]  m_tag   [3][4096];
  bit          m_tv    [3][4096];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hera_dmem_responder #(
      .ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk(clk), .rst(rst),
      .ram_addr(addr[g]), .ram_read(rd[g]), .ram_write(wr[g]),
      .ram_data(wdat[g]), .ram_flag_wr(fwr[g]), .ram_flag_rd(frd[g]),
      .flags_in(fin[g]),
      .rd_data(rdd[g]), .rd_valid(rv[g]), .busy(bsy[g]),
      .flags_from_ram(ffr[g]), .err(er[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in(input int k);
    rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
    fwr[k] = 1'b0; frd[k] = 1'b0; fin[k] = 2'b00;
  endtask

  // Issue one request from a negedge; returns at the negedge of the last
  // cycle of the access (the response cycle for reads).
  task automatic txn(input int k, input bit r, input bit w, input logic [11:0] a,
                     input logic [15:0] d, input bit fw, input bit fr, input logic [1:0] fi);
    int          lat;
    int          guard;
    logic [15:0] exp_d;
    bit          exp_known;
    logic [2:0]  exp_f;
    bit          is_rd;
    lat   = wc(k);
    is_rd = r && !w;
    exp_d = '0; exp_known = 1'b0; exp_f = 3'b000;
    guard = 0;
    while (bsy[k] === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("busy_timeout", 32'd1, 32'd0);
    rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d;
    fwr[k] = fw; frd[k] = fr; fin[k] = fi;
    @(posedge clk);
    if (w) begin
      m_mem[k][a]   = d;
      m_known[k][a] = 1'b1;
      m_tag[k][a]   = fw ? fi : 2'b00;
      m_tv[k][a]    = fw;
    end else begin
      exp_d     = m_mem[k][a];
      exp_known = m_known[k][a];
      exp_f     = (fr && m_tv[k][a]) ? {1'b1, m_tag[k][a]} : 3'b000;
    end
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        clr_in(k);
        chk("err", 32'(er[k]), 32'(r && w));
      end
      chk("busy", 32'(bsy[k]), 32'(n <= lat));
      chk("rd_valid", 32'(rv[k]), 32'(is_rd && n == lat + 1));
      if (is_rd && n == lat + 1) begin
        if (exp_known) chk("rd_data", 32'(rdd[k]), 32'(exp_d));
        chk("flags", 32'(ffr[k]), 32'(exp_f));
      end else begin
        chk("flags_idle", 32'(ffr[k]), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) clr_in(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      chk("rst_rv", 32'(rv[k]), 32'd0);
      chk("rst_rdd", 32'(rdd[k]), 32'd0);
      chk("rst_flags", 32'(ffr[k]), 32'd0);
      chk("rst_err", 32'(er[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // One wait state: plain write then read
    txn(1, 0, 1, 12'h010, 16'hBEEF, 0, 0, 2'b00);
    txn(1, 1, 0, 12'h010, 16'h0000, 0, 0, 2'b00);

    // Zero wait states: back-to-back reads
    txn(0, 0, 1, 12'h000, 16'h1111, 0, 0, 2'b00);
    txn(0, 0, 1, 12'h001, 16'h2222, 0, 0, 2'b00);
    txn(0, 1, 0, 12'h000, 16'h0000, 0, 0, 2'b00);
    txn(0, 1, 0, 12'h001, 16'h0000, 0, 0, 2'b00);

    // Flag tagging, then untagging by a plain rewrite
    txn(1, 0, 1, 12'h0FF, 16'h1234, 1, 0, 2'b10);
    txn(1, 1, 0, 12'h0FF, 16'h0000, 0, 1, 2'b00);
    txn(1, 0, 1, 12'h0FF, 16'h5678, 0, 0, 2'b11);
    txn(1, 1, 0, 12'h0FF, 16'h0000, 0, 1, 2'b00);

    // Read and write together behaves as a write
    txn(1, 1, 1, 12'h020, 16'h00AA, 0, 0, 2'b00);
    txn(1, 1, 0, 12'h020, 16'h0000, 0, 0, 2'b00);

    // Write accepted in the response cycle of a read to the same word
    txn(1, 0, 1, 12'h040, 16'h0001, 0, 0, 2'b00);
    txn(1, 1, 0, 12'h040, 16'h0000, 0, 0, 2'b00);
    txn(1, 0, 1, 12'h040, 16'h0002, 0, 0, 2'b00);
    chk("rd_data_hold", 32'(rdd[1]), 32'h0001);
    txn(1, 1, 0, 12'h040, 16'h0000, 0, 0, 2'b00);

    // Reset during the second wait cycle of a three-wait read
    txn(2, 0, 1, 12'h030, 16'hC0DE, 1, 0, 2'b01);
    rd[2] = 1'b1; addr[2] = 12'h030; frd[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_in(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bsy[2]), 32'd0);
    chk("abort_rv", 32'(rv[2]), 32'd0);
    chk("abort_rdd", 32'(rdd[2]), 32'd0);
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 4096; a++) m_tv[k][a] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(rv[2]), 32'd0);
    end
    txn(2, 1, 0, 12'h030, 16'h0000, 0, 1, 2'b00);

    // Randomized traffic on every instance
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 30; t++) begin
        op = $urandom_range(0, 3);
        txn(k, op != 1, op == 1 || op == 2, 12'($urandom_range(0, 15)),
            16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hera_dmem_responder.md
Name: hera_dmem_responder

Overview:
- Data-memory responder at the far end of the core's RAM request interface.
- Accepts word read and write requests issued by the execute stage: `ram_addr`, `ram_write`, `ram_read`, `ram_data`.
- Returns read data after a programmable wait, and stalls the core with `busy` while a request is outstanding.
- Keeps a 2-bit flag tag per word, written by CALL-style stores and returned on RETURN-style loads, to drive `flags_from_ram`.

Parameters:
- ADDR_W, 12, word address width; depth is 2**ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 1, extra wait states per access; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ram_addr  input  ADDR_W  word address of request.
- ram_read  input  1  read request.
- ram_write  input  1  write request.
- ram_data  input  DATA_W  write data.
- ram_flag_wr  input  1  with ram_write: store flags_in as the word's tag.
- ram_flag_rd  input  1  with ram_read: return the tag on flags_from_ram.
- flags_in  input  2  {sign, zero} to tag.
- rd_data  output  DATA_W  read response data.
- rd_valid  output  1  one-cycle read response strobe.
- busy  output  1  core must hold its request while high.
- flags_from_ram  output  3  {tag_valid, sign, zero}; nonzero only in the rd_valid cycle of a flag read.
- err  output  1  one-cycle pulse on illegal simultaneous read+write.

Behaviour:
- Storage: DATA_W x 2**ADDR_W data array, not reset. Parallel 2-bit tag array plus a tag_valid bit per word; all tag_valid bits clear on reset.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: counting wait states.
  - RESP: read response cycle.
- busy = (state == WAIT).
- Accept condition: request accepted on a rising edge when state is IDLE or RESP and (ram_read | ram_write).
- Write:
  - Memory is updated at the accept edge.
  - ram_flag_wr=1: tag <= flags_in and tag_valid <= 1. ram_flag_wr=0: tag_valid <= 0.
  - Next state: WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else IDLE.
  - A write never produces rd_valid.
- Read:
  - Address and the ram_flag_rd bit are latched at the accept edge.
  - WAIT_CYCLES = 0: next state is RESP. Otherwise WAIT with counter = WAIT_CYCLES-1.
  - WAIT decrements the counter each cycle. At counter 0 the next state is RESP for a pending read, or IDLE for a write.
  - rd_data is registered from mem[addr_q] on the edge entering RESP.
  - Read latency: rd_valid is high in the cycle WAIT_CYCLES+1 edges after the accept edge.
- RESP: rd_valid = 1 for exactly one cycle. A new request may be accepted in this cycle (back-to-back). Without a request the next state is IDLE.
- rd_data holds its last response value until the next read response; reset value 0.
- flags_from_ram:
  - In the RESP cycle of a read with latched ram_flag_rd=1: equals {tag_valid, tag[1], tag[0]} of the read address.
  - Otherwise: 3'b000.
- Simultaneous ram_read & ram_write: treated as a write only; err = 1 in the following cycle.
- Write accepted in RESP to the same address being returned: rd_data shows the old value (already registered); the new value is visible on the next read.
- Requests presented while busy=1 are ignored; the core must hold them.
- Reset:
  - Asynchronously forces state = IDLE; busy, rd_valid, err, flags_from_ram, rd_data and the counter to 0.
  - A pending read is discarded.
  - A write committed before reset remains in memory; its tag is invalidated by the global tag_valid clear.
- Address wraps naturally within ADDR_W bits; there is no out-of-range case.

Test Plan:
- WAIT_CYCLES=1. Write 16'hBEEF to 12'h010, then read 12'h010 → busy high 1 cycle after each accept; rd_valid exactly 2 edges after the read accept, with rd_data=16'hBEEF and flags_from_ram=3'b000.
- WAIT_CYCLES=0. Back-to-back reads of 12'h000 then 12'h001 (preloaded 16'h1111, 16'h2222) → busy never high; rd_valid on consecutive cycles returning 16'h1111 then 16'h2222.
- Flag path:
  - Write 12'h0FF with ram_flag_wr=1, flags_in=2'b10, then read with ram_flag_rd=1 → flags_from_ram=3'b110.
  - Plain rewrite of 12'h0FF, then flag read → flags_from_ram=3'b000.
- ram_read and ram_write both high, addr 12'h020, data 16'h00AA → err pulses 1 cycle; no rd_valid; a later read returns 16'h00AA.
- WAIT_CYCLES=3. Assert rst during the second WAIT cycle of a read → busy, rd_valid, rd_data=0 immediately; no response follows. A subsequent read completes in 4 edges.
- RESP-cycle write to the address being returned (old 16'h0001, new 16'h0002) → that rd_valid shows 16'h0001; the next read returns 16'h0002.
